// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM encoding, special instruction words and default widths.
package instruction_fetch_pkg;

  localparam int DEF_NB_DATA         = 32;
  localparam int DEF_NB_JUMP_ADDRESS = 26;
  localparam int DEF_NB_MEM_ADDRESS  = 8;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Instruction memory: one synchronous write port, one
// combinational read port. Contents survive reset.
module instruction_memory #(
  parameter int NB_DATA        = 32,
  parameter int NB_MEM_ADDRESS = 8
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [NB_MEM_ADDRESS-1:0] waddr_i,
  input  logic [NB_DATA-1:0]        wdata_i,
  input  logic [NB_MEM_ADDRESS-1:0] raddr_i,
  output logic [NB_DATA-1:0]        rdata_o
);

  logic [NB_DATA-1:0] mem [2**NB_MEM_ADDRESS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, next-PC selection, IF/ID register and
// the run/step/halt control FSM.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA         = DEF_NB_DATA,
  parameter int NB_JUMP_ADDRESS = DEF_NB_JUMP_ADDRESS,
  parameter int NB_MEM_ADDRESS  = DEF_NB_MEM_ADDRESS
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_step_mode,
  input  logic                       i_step,
  input  logic                       i_stall,
  input  logic                       i_branch_taken,
  input  logic [NB_DATA-1:0]         i_branch_offset,
  input  logic                       i_jump,
  input  logic [NB_JUMP_ADDRESS-1:0] i_jump_address,
  input  logic                       i_jump_reg,
  input  logic [NB_DATA-1:0]         i_jump_reg_target,
  input  logic                       i_mem_wr_en,
  input  logic [NB_MEM_ADDRESS-1:0]  i_mem_wr_addr,
  input  logic [NB_DATA-1:0]         i_mem_wr_data,
  output logic [NB_DATA-1:0]         o_instruction,
  output logic [NB_DATA-1:0]         o_pc_plus4,
  output logic [NB_DATA-1:0]         o_pc,
  output logic                       o_halted
);

  if_state_t          state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;

  logic [NB_DATA-1:0] fetch_word;
  logic [NB_DATA-1:0] pc_inc;
  logic [NB_DATA-1:0] jump_tgt;
  logic [NB_DATA-1:0] branch_tgt;
  logic               redirect;
  logic               adv;

  instruction_memory #(
    .NB_DATA        (NB_DATA),
    .NB_MEM_ADDRESS (NB_MEM_ADDRESS)
  ) u_imem (
    .clk_i   (i_clock),
    .we_i    (i_mem_wr_en && (state_q == IDLE)),
    .waddr_i (i_mem_wr_addr),
    .wdata_i (i_mem_wr_data),
    .raddr_i (pc_q[NB_MEM_ADDRESS+1:2]),
    .rdata_o (fetch_word)
  );

  assign pc_inc     = pc_q + NB_DATA'(4);
  assign jump_tgt   = {pc4_q[NB_DATA-1:NB_JUMP_ADDRESS+2],
                       i_jump_address, 2'b00};
  assign branch_tgt = pc4_q + (i_branch_offset << 2);
  assign redirect   = i_jump_reg | i_jump | i_branch_taken;
  assign adv        = ((state_q == RUN) ||
                       ((state_q == STEP) && i_step)) && !i_stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    unique case (state_q)
      IDLE: begin
        instr_d = NB_DATA'(NOP);
        if (i_start) state_d = i_step_mode ? STEP : RUN;
      end
      RUN, STEP: begin
        if (adv) begin
          if (redirect) begin
            // no delay slot: squash the wrong-path fetch
            instr_d = NB_DATA'(NOP);
            pc4_d   = '0;
            if (i_jump_reg)  pc_d = i_jump_reg_target;
            else if (i_jump) pc_d = jump_tgt;
            else             pc_d = branch_tgt;
          end else if (fetch_word == NB_DATA'(HALT)) begin
            instr_d = fetch_word;
            pc4_d   = pc_inc;
            state_d = HALTED;
          end else begin
            instr_d = fetch_word;
            pc4_d   = pc_inc;
            pc_d    = pc_inc;
          end
        end
      end
      HALTED: begin
        if (!i_stall) begin
          instr_d = NB_DATA'(NOP);
          pc4_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc_plus4    = pc4_q;
  assign o_pc          = pc_q;
  assign o_halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues
// hand-computed expectations, a monitor checks at negedge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_step_mode, i_step, i_stall;
  logic        i_branch_taken, i_jump, i_jump_reg, i_mem_wr_en;
  logic [31:0] i_branch_offset, i_jump_reg_target, i_mem_wr_data;
  logic [25:0] i_jump_address;
  logic [7:0]  i_mem_wr_addr;
  logic [31:0] o_instruction, o_pc_plus4, o_pc;
  logic        o_halted;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] W0  = 32'h2001_0005;
  localparam logic [31:0] W1  = 32'h2002_0007;
  localparam logic [31:0] HLT = 32'hFFFF_FFFF;
  localparam logic [31:0] W4  = 32'h0000_0404;
  localparam logic [31:0] W5  = 32'h0000_0505;
  localparam logic [31:0] W16 = 32'h0000_1616;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .i_clock           (clk),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_step_mode       (i_step_mode),
    .i_step            (i_step),
    .i_stall           (i_stall),
    .i_branch_taken    (i_branch_taken),
    .i_branch_offset   (i_branch_offset),
    .i_jump            (i_jump),
    .i_jump_address    (i_jump_address),
    .i_jump_reg        (i_jump_reg),
    .i_jump_reg_target (i_jump_reg_target),
    .i_mem_wr_en       (i_mem_wr_en),
    .i_mem_wr_addr     (i_mem_wr_addr),
    .i_mem_wr_data     (i_mem_wr_data),
    .o_instruction     (o_instruction),
    .o_pc_plus4        (o_pc_plus4),
    .o_pc              (o_pc),
    .o_halted          (o_halted)
  );

  task automatic chk(string n, string f, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "pc", o_pc, e.pc);
      chk(e.name, "instr", o_instruction, e.instr);
      chk(e.name, "pc4", o_pc_plus4, e.pc4);
      chk(e.name, "halted", {31'd0, o_halted}, {31'd0, e.halted});
    end
  end

  task automatic clr();
    i_start = 0; i_step_mode = 0; i_step = 0; i_stall = 0;
    i_branch_taken = 0; i_branch_offset = '0;
    i_jump = 0; i_jump_address = '0;
    i_jump_reg = 0; i_jump_reg_target = '0;
    i_mem_wr_en = 0; i_mem_wr_addr = '0; i_mem_wr_data = '0;
  endtask

  task automatic tick(string n, logic [31:0] pc,
                      logic [31:0] ins, logic [31:0] p4,
                      logic h);
    exp_t e;
    @(posedge clk);
    e.name = n; e.pc = pc; e.instr = ins;
    e.pc4 = p4; e.halted = h;
    q.push_back(e);
    #1;
    clr();
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    i_mem_wr_en = 1; i_mem_wr_addr = a; i_mem_wr_data = d;
    tick("load", 0, 0, 0, 0);
  endtask

  task automatic run_prog_a(string tag);
    i_start = 1; i_step_mode = 0;
    tick({tag, "_start"}, 0, 0, 0, 0);
    tick({tag, "_f0"}, 4, W0, 4, 0);
    tick({tag, "_f1"}, 8, W1, 8, 0);
    tick({tag, "_fhalt"}, 8, HLT, 12, 1);
    i_stall = 1;
    tick({tag, "_hstall"}, 8, HLT, 12, 1);
    tick({tag, "_drain"}, 8, 0, 0, 1);
    tick({tag, "_drain2"}, 8, 0, 0, 1);
  endtask

  initial begin
    clr();
    i_reset = 0;
    tick("rst0", 0, 0, 0, 0);
    tick("rst1", 0, 0, 0, 0);
    i_reset = 1;
    wr(8'd0, W0);
    wr(8'd1, W1);
    wr(8'd2, HLT);
    wr(8'd4, W4);
    wr(8'd5, W5);
    wr(8'd16, W16);
    wr(8'd32, HLT);

    run_prog_a("a");
    i_reset = 0;
    tick("rst_halt", 0, 0, 0, 0);
    i_reset = 1;

    i_start = 1;
    tick("b_start", 0, 0, 0, 0);
    tick("b_f0", 4, W0, 4, 0);
    i_stall = 1; i_branch_taken = 1; i_branch_offset = 32'd3;
    i_mem_wr_en = 1; i_mem_wr_addr = 8'd2;
    i_mem_wr_data = 32'h1234_5678;
    tick("stall1", 4, W0, 4, 0);
    i_stall = 1; i_jump = 1; i_jump_address = 26'h10;
    tick("stall2", 4, W0, 4, 0);
    tick("b_f1", 8, W1, 8, 0);
    i_branch_taken = 1; i_branch_offset = 32'd3;
    tick("branch", 20, 0, 0, 0);
    tick("f5", 24, W5, 24, 0);
    i_jump = 1; i_jump_address = 26'h10;
    tick("jump", 32'h40, 0, 0, 0);
    tick("f16", 32'h44, W16, 32'h44, 0);
    i_jump = 1; i_jump_address = 26'h10;
    i_jump_reg = 1; i_jump_reg_target = 32'h80;
    tick("jr_prio", 32'h80, 0, 0, 0);
    i_jump = 1; i_jump_address = 26'h4;
    tick("halt_sq", 32'h10, 0, 0, 0);
    tick("f4", 32'h14, W4, 32'h14, 0);
    i_branch_taken = 1; i_branch_offset = 32'hFFFF_FFFB;
    tick("br_neg", 0, 0, 0, 0);
    tick("c_f0", 4, W0, 4, 0);
    i_jump_reg = 1; i_jump_reg_target = 32'h414;
    tick("alias_j", 32'h414, 0, 0, 0);
    tick("alias_f", 32'h418, W5, 32'h418, 0);
    i_reset = 0; i_stall = 1;
    tick("rst_run", 0, 0, 0, 0);
    i_reset = 1;
    tick("idle", 0, 0, 0, 0);

    i_start = 1; i_step_mode = 1;
    tick("s_start", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("s_wait", 0, 0, 0, 0);
    i_step = 1;
    tick("s_step", 4, W0, 4, 0);
    tick("s_hold", 4, W0, 4, 0);
    i_step = 1; i_stall = 1;
    tick("s_stall", 4, W0, 4, 0);
    i_step = 1;
    tick("s_step2", 8, W1, 8, 0);
    i_reset = 0;
    tick("rst_step", 0, 0, 0, 0);
    i_reset = 1;

    run_prog_a("rerun");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 NB_DATA, default 32: data, instruction and PC width.
REQ-002 NB_JUMP_ADDRESS, default 26: jump target field width.
REQ-003 NB_MEM_ADDRESS, default 8: instruction memory word-address width (256 words).
REQ-004 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-low reset.
REQ-006 i_start  in  1  leave IDLE and begin fetching.
REQ-007 i_step_mode  in  1  sampled with i_start; 1 selects single-step execution.
REQ-008 i_step  in  1  one-cycle pulse; advances the stage once in STEP.
REQ-009 i_stall  in  1  hazard-unit stall; holds PC and the IF/ID register.
REQ-010 i_branch_taken  in  1  branch resolved taken in ID.
REQ-011 i_branch_offset  in  NB_DATA  sign-extended branch immediate, in words.
REQ-012 i_jump  in  1  J/JAL decoded in ID.
REQ-013 i_jump_address  in  NB_JUMP_ADDRESS  instr[25:0] of the jump.
REQ-014 i_jump_reg  in  1  JR/JALR decoded in ID.
REQ-015 i_jump_reg_target  in  NB_DATA  forwarded rs value for JR/JALR.
REQ-016 i_mem_wr_en / i_mem_wr_addr (NB_MEM_ADDRESS) / i_mem_wr_data (NB_DATA)  in  program-loader write port.
REQ-017 o_instruction  out  NB_DATA  IF/ID register: instruction presented to decode.
REQ-018 o_pc_plus4  out  NB_DATA  IF/ID register: PC+4 of that instruction (return address, branch base).
REQ-019 o_pc  out  NB_DATA  current PC, for debug.
REQ-020 o_halted  out  1  high while the FSM is in HALTED.

Function
REQ-021 FSM states IDLE, RUN, STEP, HALTED; IDLE->RUN on i_start with i_step_mode=0, IDLE->STEP on i_start with i_step_mode=1; HALTED is left only by reset.
REQ-022 adv = (RUN or (STEP and i_step)) and not i_stall; PC and the IF/ID register change only when adv=1, except in HALTED (REQ-027).
REQ-023 On adv, next PC priority: i_jump_reg -> i_jump_reg_target; else i_jump -> {o_pc_plus4[31:28], i_jump_address, 2'b00}; else i_branch_taken -> o_pc_plus4 + (i_branch_offset << 2); else PC+4.
REQ-024 All PC arithmetic is 32-bit modulo; the memory index is PC[NB_MEM_ADDRESS+1:2], so PCs beyond 1 KiB alias.
REQ-025 On adv with any redirect asserted, IF/ID loads instruction 32'h0000_0000 (NOP) and pc_plus4 0; the no-delay-slot flush takes one bubble.
REQ-026 On adv with no redirect, IF/ID loads mem[PC index] and PC+4.
REQ-027 When the word fetched is 32'hFFFF_FFFF (HALT) and there is no redirect, IF/ID latches it, PC holds, and the FSM goes to HALTED. In HALTED, IF/ID loads NOP on every non-stalled cycle so the pipeline drains.
REQ-028 If a HALT fetch coincides with a redirect, the redirect wins and the HALT is squashed.
REQ-029 i_stall overrides everything: any redirect in a stalled cycle is ignored, and ID re-presents it the next cycle.
REQ-030 Memory writes take effect only in IDLE and are ignored in other states; reads are combinational from the array.
REQ-031 In IDLE, o_instruction=0 and PC holds.

Reset
REQ-032 On a clock edge with i_reset=0: state=IDLE, PC=0, o_instruction=0, o_pc_plus4=0, o_halted=0, regardless of state or stall.
REQ-033 Reset does not clear instruction memory contents.

Structure
REQ-034 A shared package holds the FSM state encoding, NOP (32'h0) and HALT (32'hFFFF_FFFF) constants, and the default widths.
REQ-035 Instruction memory is a sub-module, instruction_memory (one write port, one asynchronous read port); the PC, next-PC mux, IF/ID register and FSM stay in instruction_fetch.

Verification
REQ-036 Load 0x20010005, 0x20020007, 0xFFFFFFFF at words 0..2, then start with step mode 0 -> o_instruction shows those words on three consecutive cycles with o_pc_plus4 4, 8, 12; o_halted=1 next cycle; PC stays 8; later o_instruction=0.
REQ-037 i_stall high for 2 cycles at PC=4 -> o_pc, o_instruction and o_pc_plus4 unchanged both cycles; resume to PC=8.
REQ-038 o_pc_plus4=8, i_branch_taken with offset 3 -> PC=20, o_instruction=0 next cycle; branch asserted with i_stall -> PC unchanged.
REQ-039 i_jump with address 0x10 -> PC=0x40; i_jump and i_jump_reg (target 0x80) together -> PC=0x80; HALT fetched with a jump -> no halt.
REQ-040 Step mode, 4 cycles without i_step -> PC constant; one i_step pulse -> exactly one advance. Memory write attempted in RUN -> contents unchanged.
REQ-041 i_reset low mid-RUN -> next edge PC=0, outputs 0, IDLE; memory retains contents and re-runs identically on i_start.
